// File: rtl/tone_seq_pkg.sv
// Shared types and constants for the tone sequencer.
package tone_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        GAP
    } state_e;

    localparam logic [2:0] TONE_DO  = 3'd0;
    localparam logic [2:0] TONE_RE  = 3'd1;
    localparam logic [2:0] TONE_MI  = 3'd2;
    localparam logic [2:0] TONE_FA  = 3'd3;
    localparam logic [2:0] TONE_SO  = 3'd4;
    localparam logic [2:0] TONE_LA  = 3'd5;
    localparam logic [2:0] TONE_TI  = 3'd6;
    localparam logic [2:0] TONE_DO2 = 3'd7;

    localparam logic [2:0] FIRST_ASC  = TONE_DO;
    localparam logic [2:0] FIRST_DESC = TONE_DO2;

endpackage

// File: rtl/square_wave_gen.sv
// Square-wave generator: half-period counter plus toggle flop.
// A zero divisor is treated as 1, so the output then toggles every cycle.
// The >= compare keeps a shrinking divisor from forcing a full counter wrap.
module square_wave_gen #(
    parameter int DIV_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             wave
);

    logic [DIV_W-1:0] hp_q, hp_d;
    logic [DIV_W-1:0] hp_limit;
    logic             wave_q, wave_d;

    // Next half-period count and wave level; disabled or cleared means silent and restarted.
    always_comb begin
        // NOTE: every variable gets a default first, so no path leaves one unassigned and no latch appears.
        hp_limit = (div == '0) ? '0 : div - 1'b1;
        hp_d     = hp_q + 1'b1;
        wave_d   = wave_q;
        if (!en || clr) begin
            hp_d   = '0;
            wave_d = 1'b0;
        end else if (hp_q >= hp_limit) begin
            hp_d   = '0;
            wave_d = ~wave_q;
        end
    end

    // Counter and toggle flop registers.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
        if (reset) begin
            hp_q   <= '0;
            wave_q <= 1'b0;
        end else begin
            hp_q   <= hp_d;
            wave_q <= wave_d;
        end
    end

    assign wave = wave_q;

endmodule

// File: rtl/tone_sequencer.sv
// Tone sequencer: steps an 8-note divider through an ascending or descending
// scale, or sounds one switch-selected tone in manual mode while idle.
// Optional macro TONE_SEQ_GAP_EN inserts GAP_TICKS of silence between notes.
module tone_sequencer
    import tone_seq_pkg::*;
#(
    parameter int NOTE_TICKS = 25_000_000,
    parameter int GAP_TICKS  = 2_500_000,
    parameter int DIV_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             dir,
    input  logic             manual_en,
    input  logic [2:0]       manual_tone,
    output logic [2:0]       tone_sel,
    input  logic [DIV_W-1:0] div_in,
    output logic             audio_out,
    output logic             busy,
    output logic             note_strobe,
    output logic             done
);

    if (NOTE_TICKS < 2 || GAP_TICKS < 1) begin : g_bad_params
        $error("tone_sequencer: NOTE_TICKS must be >= 2 and GAP_TICKS >= 1");
    end

    localparam int             NW        = $clog2(NOTE_TICKS);
    localparam logic [NW-1:0]  NOTE_LAST = NW'(NOTE_TICKS - 1);
`ifdef TONE_SEQ_GAP_EN
    localparam int             GW        = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
    localparam logic [GW-1:0]  GAP_LAST  = GW'(GAP_TICKS - 1);
    logic [GW-1:0] gap_cnt_q;
`endif

    state_e        state_q;
    logic [NW-1:0] note_cnt_q;
    logic [2:0]    tone_sel_q;
    logic          dir_q;
    logic          busy_q;
    logic          note_strobe_q;
    logic          done_q;

    logic          note_last;
    logic [2:0]    last_idx;
    logic [2:0]    next_idx;
    logic          sw_en;
    logic          sw_clr;

    assign note_last = (note_cnt_q == NOTE_LAST);
    assign last_idx  = dir_q ? FIRST_ASC : FIRST_DESC;
    assign next_idx  = dir_q ? tone_sel_q - 3'd1 : tone_sel_q + 3'd1;

    // Square-wave control: run while playing or in manual idle, restart on every note entry or tone change.
    always_comb begin
        sw_en  = 1'b0;
        sw_clr = 1'b0;
        if (!stop) begin
            case (state_q)
                IDLE: begin
                    sw_en  = manual_en;
                    sw_clr = manual_en && (manual_tone != tone_sel_q);
                end
                PLAY: begin
                    sw_en  = 1'b1;
                    sw_clr = note_last;
                end
                default: ;
            endcase
        end
    end

    // Sequencer FSM with note/gap counters, index stepping and registered status pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            note_cnt_q    <= '0;
            tone_sel_q    <= '0;
            dir_q         <= 1'b0;
            busy_q        <= 1'b0;
            note_strobe_q <= 1'b0;
            done_q        <= 1'b0;
`ifdef TONE_SEQ_GAP_EN
            gap_cnt_q     <= '0;
`endif
        end else begin
            note_strobe_q <= 1'b0;
            done_q        <= 1'b0;
            if (stop) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (manual_en) begin
                            tone_sel_q <= manual_tone;
                        end else if (start) begin
                            state_q       <= PLAY;
                            dir_q         <= dir;
                            tone_sel_q    <= dir ? FIRST_DESC : FIRST_ASC;
                            note_cnt_q    <= '0;
                            note_strobe_q <= 1'b1;
                            busy_q        <= 1'b1;
                        end
                    end
                    PLAY: begin
                        if (note_last) begin
                            note_cnt_q <= '0;
                            if (tone_sel_q == last_idx) begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end else begin
                                tone_sel_q <= next_idx;
`ifdef TONE_SEQ_GAP_EN
                                state_q    <= GAP;
                                gap_cnt_q  <= '0;
`else
                                note_strobe_q <= 1'b1;
`endif
                            end
                        end else begin
                            note_cnt_q <= note_cnt_q + 1'b1;
                        end
                    end
`ifdef TONE_SEQ_GAP_EN
                    GAP: begin
                        if (gap_cnt_q == GAP_LAST) begin
                            state_q       <= PLAY;
                            note_cnt_q    <= '0;
                            note_strobe_q <= 1'b1;
                        end else begin
                            gap_cnt_q <= gap_cnt_q + 1'b1;
                        end
                    end
`endif
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    square_wave_gen #(
        .DIV_W (DIV_W)
    ) u_wave (
        .clk   (clk),
        .reset (reset),
        .clr   (sw_clr),
        .en    (sw_en),
        .div   (div_in),
        .wave  (audio_out)
    );

    assign tone_sel    = tone_sel_q;
    assign busy        = busy_q;
    assign note_strobe = note_strobe_q;
    assign done        = done_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer with a behavioural divider (4 + index).
// Expectations adapt to whether TONE_SEQ_GAP_EN is defined for the build.
module tb_tone_sequencer;

    localparam int NOTE_TICKS = 100;
    localparam int GAP_TICKS  = 10;
    localparam int DIV_W      = 32;
`ifdef TONE_SEQ_GAP_EN
    localparam int GAP = GAP_TICKS;
`else
    localparam int GAP = 0;
`endif
    localparam int PERIOD    = NOTE_TICKS + GAP;
    localparam int RUN_LEN   = 8 * NOTE_TICKS + 7 * GAP;
    localparam int RUN_LIMIT = 2000;

    logic             clk = 1'b0;
    logic             reset;
    logic             start, stop, dir, manual_en;
    logic [2:0]       manual_tone;
    logic [2:0]       tone_sel;
    logic [DIV_W-1:0] div_in;
    logic             audio_out, busy, note_strobe, done;

    logic             stub_en;
    logic [DIV_W-1:0] stub_val;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Behavioural divider: half-period of 4 + index, or a forced stub value.
    always_comb div_in = stub_en ? stub_val : DIV_W'(4 + int'(tone_sel));

    tone_sequencer #(
        .NOTE_TICKS (NOTE_TICKS),
        .GAP_TICKS  (GAP_TICKS),
        .DIV_W      (DIV_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .dir         (dir),
        .manual_en   (manual_en),
        .manual_tone (manual_tone),
        .tone_sel    (tone_sel),
        .div_in      (div_in),
        .audio_out   (audio_out),
        .busy        (busy),
        .note_strobe (note_strobe),
        .done        (done)
    );

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One full scale run; sample n is taken after the n-th edge following the start pulse.
    task automatic run_scale(input logic d, input int extra_start_at);
        int strobes, done_cnt, done_at, busy_cyc, gap_cyc, gap_audio;
        int first_idx, last_idx, div_first, div_last;
        int e_first[$];
        int e_last[$];
        logic prev_audio;
        logic in_gap;
        strobes = 0; done_cnt = 0; done_at = -1; busy_cyc = 0; gap_cyc = 0; gap_audio = 0;
        first_idx = d ? 7 : 0;
        last_idx  = d ? 0 : 7;
        div_first = 4 + first_idx;
        div_last  = 4 + last_idx;
        prev_audio = 1'b0;
        start = 1'b1; dir = d;
        tick();
        start = 1'b0;
        for (int n = 1; n <= RUN_LIMIT; n++) begin
            in_gap = ((n - 1) % PERIOD) >= NOTE_TICKS;
            if (note_strobe) begin
                check("strobe_idx", 32'(tone_sel), d ? 32'(7 - strobes) : 32'(strobes));
                check("strobe_time", n, 1 + strobes * PERIOD);
                strobes++;
            end
            if (busy) busy_cyc++;
            if (busy && in_gap) begin
                gap_cyc++;
                if (audio_out) gap_audio++;
            end
            if (audio_out != prev_audio && busy && !note_strobe && !in_gap) begin
                if (tone_sel == 3'(first_idx)) e_first.push_back(n);
                else if (tone_sel == 3'(last_idx)) e_last.push_back(n);
            end
            prev_audio = audio_out;
            if (done) begin
                done_cnt++;
                done_at = n;
            end
            if (done_cnt > 0 && n >= done_at + 3) break;
            start = (n == extra_start_at);
            dir   = (n == extra_start_at) ? ~d : d;
            tick();
        end
        start = 1'b0; dir = d;
        check("run_strobes", strobes, 8);
        check("run_done_count", done_cnt, 1);
        check("run_done_time", done_at, 1 + RUN_LEN);
        check("run_busy_cycles", busy_cyc, RUN_LEN);
        check("run_gap_cycles", gap_cyc, 7 * GAP);
        check("run_gap_audio", gap_audio, 0);
        check("run_busy_after", 32'(busy), 0);
        check("first_note_edge0", (e_first.size() > 0) ? e_first[0] : -1, 1 + div_first);
        check("first_note_edge1", (e_first.size() > 1) ? e_first[1] : -1, 1 + 2 * div_first);
        check("first_note_edges", e_first.size(), 99 / div_first);
        check("last_note_edge0", (e_last.size() > 0) ? e_last[0] : -1, 1 + 7 * PERIOD + div_last);
        check("last_note_edges", e_last.size(), 99 / div_last);
    endtask

    initial begin
        int edges[$];
        int cnt;
        logic prev;

        reset = 1'b1; start = 1'b0; stop = 1'b0; dir = 1'b0;
        manual_en = 1'b0; manual_tone = 3'd0; stub_en = 1'b0; stub_val = '0;

        // Reset state.
        @(negedge clk);
        check("rst_tone_sel", 32'(tone_sel), 0);
        check("rst_audio", 32'(audio_out), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_strobe", 32'(note_strobe), 0);
        check("rst_done", 32'(done), 0);
        reset = 1'b0;
        tick();

        // Ascending run.
        run_scale(1'b0, -1);
        tick();

        // Descending run.
        run_scale(1'b1, -1);
        tick();

        // Stop at sample 250, then restart on the following cycle.
        start = 1'b1; dir = 1'b0;
        tick();
        start = 1'b0;
        for (int i = 1; i < 250; i++) tick();
        check("pre_stop_busy", 32'(busy), 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stop_busy", 32'(busy), 0);
        check("stop_audio", 32'(audio_out), 0);
        check("stop_done", 32'(done), 0);
        check("stop_tone_hold", 32'(tone_sel), 2);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_strobe", 32'(note_strobe), 1);
        check("restart_tone", 32'(tone_sel), 0);
        check("restart_busy", 32'(busy), 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (done || busy) cnt++;
            tick();
        end
        check("stop_quiet", cnt, 0);

        // start and stop together: stop wins.
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        check("startstop_busy", 32'(busy), 0);
        check("startstop_strobe", 32'(note_strobe), 0);
        tick();
        check("startstop_late", 32'(busy), 0);

        // Start pulse with the opposite direction while busy is ignored.
        run_scale(1'b0, 50);
        tick();

        // Manual mode with stub divisor 3; start held high throughout.
        stub_en = 1'b1; stub_val = 32'd3;
        manual_en = 1'b1; manual_tone = 3'd5; start = 1'b1;
        tick();
        check("manual_tone5", 32'(tone_sel), 5);
        prev = 1'b0; cnt = 0;
        for (int m = 1; m <= 5; m++) begin
            if (audio_out != prev) edges.push_back(m);
            if (busy) cnt++;
            prev = audio_out;
            if (m < 5) tick();
        end
        check("manual_edge_first", (edges.size() > 0) ? edges[0] : -1, 4);
        check("manual_edge_count", edges.size(), 1);
        edges.delete();
        manual_tone = 3'd2;
        tick();
        check("manual_tone2", 32'(tone_sel), 2);
        check("manual_restart_audio", 32'(audio_out), 0);
        prev = audio_out;
        for (int m = 7; m <= 13; m++) begin
            tick();
            if (audio_out != prev) edges.push_back(m);
            if (busy) cnt++;
            prev = audio_out;
        end
        check("manual_edge_a", (edges.size() > 0) ? edges[0] : -1, 9);
        check("manual_edge_b", (edges.size() > 1) ? edges[1] : -1, 12);
        check("manual_edge_n", edges.size(), 2);
        check("manual_start_ignored", cnt, 0);

        // Zero divisor toggles every cycle.
        stub_val = '0;
        tick();
        tick();
        prev = audio_out; cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (audio_out != prev) cnt++;
            prev = audio_out;
        end
        check("div0_toggles", cnt, 6);
        manual_en = 1'b0; start = 1'b0; stub_en = 1'b0;
        tick();
        check("manual_off_audio", 32'(audio_out), 0);

        // Asynchronous reset in the middle of note 1.
        start = 1'b1; dir = 1'b0;
        tick();
        start = 1'b0;
        for (int i = 1; i < 130; i++) tick();
        check("pre_reset_tone", 32'(tone_sel), 1);
        check("pre_reset_audio", 32'(audio_out), 1);
        #2 reset = 1'b1;
        #1;
        check("areset_tone", 32'(tone_sel), 0);
        check("areset_audio", 32'(audio_out), 0);
        check("areset_busy", 32'(busy), 0);
        check("areset_strobe", 32'(note_strobe), 0);
        check("areset_done", 32'(done), 0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        check("post_reset_idle", 32'(busy), 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("post_reset_start", 32'(note_strobe), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
